// File: rtl/fetch_sequencer.sv
// Fetch stage: PC register, IF/ID register and instruction-memory handshake.
// Stalls hold the stage; taken branches flush and redirect the PC.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hazard_stall,
   input  logic        cond_taken,
   input  logic [31:0] target_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc_out,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] pc4_q, pc4_n;
   logic        valid_q, valid_n;
   logic [31:0] rtgt, rtgt_n;
   logic [31:0] hold_buf, hold_n;
   logic [31:0] tgt;
   logic [31:0] pc_inc;

   assign tgt    = {target_addr[31:2], 2'b00};
   assign pc_inc = pc + 32'd4;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc4_q    <= 32'd0;
         valid_q  <= 1'b0;
         rtgt     <= 32'd0;
         hold_buf <= 32'd0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         instr_q  <= instr_n;
         pc4_q    <= pc4_n;
         valid_q  <= valid_n;
         rtgt     <= rtgt_n;
         hold_buf <= hold_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr_q;
      pc4_n   = pc4_q;
      valid_n = valid_q;
      rtgt_n  = rtgt;
      hold_n  = hold_buf;
      unique case (state)
         BOOT: state_n = FETCH;
         FETCH: begin
            if (cond_taken && imem_ready) begin
               pc_n    = tgt;
               instr_n = NOP_INSTR;
               valid_n = 1'b0;
            end else if (cond_taken) begin
               rtgt_n  = tgt;
               instr_n = NOP_INSTR;
               valid_n = 1'b0;
               state_n = DRAIN;
            end else if (hazard_stall && imem_ready) begin
               hold_n  = imem_rdata;
               state_n = HOLD;
            end else if (hazard_stall) begin
               state_n = FETCH;
            end else if (imem_ready) begin
               instr_n = imem_rdata;
               pc4_n   = pc_inc;
               valid_n = 1'b1;
               pc_n    = pc_inc;
            end else begin
               instr_n = NOP_INSTR;
               valid_n = 1'b0;
            end
         end
         HOLD: begin
            if (cond_taken) begin
               pc_n    = tgt;
               instr_n = NOP_INSTR;
               valid_n = 1'b0;
               state_n = FETCH;
            end else if (!hazard_stall) begin
               instr_n = hold_buf;
               pc4_n   = pc_inc;
               valid_n = 1'b1;
               pc_n    = pc_inc;
               state_n = FETCH;
            end
         end
         DRAIN: begin
            // Address must stay put until the in-flight word lands
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
            if (cond_taken) rtgt_n = tgt;
            if (imem_ready) begin
               pc_n    = cond_taken ? tgt : rtgt;
               state_n = FETCH;
            end
         end
         default: state_n = BOOT;
      endcase
   end

   assign imem_req   = (state == FETCH) || (state == DRAIN);
   assign imem_addr  = pc;
   assign pc_out     = pc;
   assign ifid_instr = instr_q;
   assign ifid_pc4   = pc4_q;
   assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory returns ~addr as the word.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        hazard_stall;
   logic        cond_taken;
   logic [31:0] target_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc_out;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   int errors = 0;
   int checks = 0;

   fetch_sequencer dut (
      .clk(clk),
      .reset(reset),
      .hazard_stall(hazard_stall),
      .cond_taken(cond_taken),
      .target_addr(target_addr),
      .imem_rdata(imem_rdata),
      .imem_ready(imem_ready),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .pc_out(pc_out),
      .ifid_instr(ifid_instr),
      .ifid_pc4(ifid_pc4),
      .ifid_valid(ifid_valid)
   );

   always #5 clk = ~clk;

   assign imem_rdata = ~imem_addr;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      hazard_stall = 1'b0;
      cond_taken = 1'b0;
      target_addr = 32'd0;
      imem_ready = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      hazard_stall = 1'b0;
      cond_taken = 1'b0;
      target_addr = 32'd0;
      imem_ready = 1'b1;
      step();
      step();
      checks++;
      if (pc_out !== 32'd0 || imem_req !== 1'b0 || ifid_valid !== 1'b0 ||
          ifid_instr !== 32'd0 || ifid_pc4 !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: pc=%h req=%b v=%b i=%h p4=%h want 0 0 0 0 0",
                  pc_out, imem_req, ifid_valid, ifid_instr, ifid_pc4);
      end
      reset = 1'b1;
      step();
      checks++;
      if (imem_req !== 1'b1 || pc_out !== 32'd0 || ifid_valid !== 1'b0) begin
         errors++;
         $display("FAIL boot_exit: req=%b pc=%h v=%b want 1 0 0",
                  imem_req, pc_out, ifid_valid);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (pc_out !== 32'(4 * k) || ifid_instr !== ~32'(4 * (k - 1)) ||
             ifid_pc4 !== 32'(4 * k) || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d: pc=%h i=%h p4=%h v=%b want %h %h %h 1",
                     k, pc_out, ifid_instr, ifid_pc4, ifid_valid,
                     32'(4 * k), ~32'(4 * (k - 1)), 32'(4 * k));
         end
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         imem_ready = 1'b0;
         for (int w = 0; w < 2; w++) begin
            step();
            checks++;
            if (imem_addr !== 32'(4 * k) || ifid_valid !== 1'b0 ||
                imem_req !== 1'b1) begin
               errors++;
               $display("FAIL wait_%0d_%0d: addr=%h v=%b req=%b want %h 0 1",
                        k, w, imem_addr, ifid_valid, imem_req, 32'(4 * k));
            end
         end
         imem_ready = 1'b1;
         step();
         checks++;
         if (pc_out !== 32'(4 * (k + 1)) || ifid_valid !== 1'b1 ||
             ifid_instr !== ~32'(4 * k) || ifid_pc4 !== 32'(4 * (k + 1))) begin
            errors++;
            $display("FAIL wait_load_%0d: pc=%h v=%b i=%h p4=%h", k,
                     pc_out, ifid_valid, ifid_instr, ifid_pc4);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      step();
      step();
      hazard_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (pc_out !== 32'h8 || ifid_instr !== ~32'h4 || ifid_pc4 !== 32'h8 ||
             ifid_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_%0d: pc=%h i=%h p4=%h v=%b req=%b want 8 %h 8 1 0",
                     c, pc_out, ifid_instr, ifid_pc4, ifid_valid, imem_req, ~32'h4);
         end
      end
      hazard_stall = 1'b0;
      step();
      checks++;
      if (pc_out !== 32'hC || ifid_instr !== ~32'h8 || ifid_pc4 !== 32'hC ||
          ifid_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: pc=%h i=%h p4=%h v=%b want C %h C 1",
                  pc_out, ifid_instr, ifid_pc4, ifid_valid, ~32'h8);
      end
      step();
      checks++;
      if (pc_out !== 32'h10 || ifid_instr !== ~32'hC || ifid_pc4 !== 32'h10) begin
         errors++;
         $display("FAIL stall_resume: pc=%h i=%h p4=%h want 10 %h 10",
                  pc_out, ifid_instr, ifid_pc4, ~32'hC);
      end
   endtask

   task automatic test_branch();
      do_reset();
      for (int k = 0; k < 4; k++) step();
      cond_taken = 1'b1;
      target_addr = 32'h0000_0103;
      step();
      cond_taken = 1'b0;
      checks++;
      if (pc_out !== 32'h100 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 ||
          ifid_pc4 !== 32'h10) begin
         errors++;
         $display("FAIL branch_bubble: pc=%h v=%b i=%h p4=%h want 100 0 0 10",
                  pc_out, ifid_valid, ifid_instr, ifid_pc4);
      end
      step();
      checks++;
      if (pc_out !== 32'h104 || ifid_valid !== 1'b1 ||
          ifid_instr !== ~32'h100 || ifid_pc4 !== 32'h104) begin
         errors++;
         $display("FAIL branch_target: pc=%h v=%b i=%h p4=%h want 104 1 %h 104",
                  pc_out, ifid_valid, ifid_instr, ifid_pc4, ~32'h100);
      end
   endtask

   task automatic test_drain();
      do_reset();
      for (int k = 0; k < 8; k++) step();
      imem_ready = 1'b0;
      step();
      cond_taken = 1'b1;
      target_addr = 32'h200;
      step();
      cond_taken = 1'b0;
      checks++;
      if (imem_addr !== 32'h20 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_enter: addr=%h req=%b v=%b want 20 1 0",
                  imem_addr, imem_req, ifid_valid);
      end
      step();
      cond_taken = 1'b1;
      target_addr = 32'h301;
      step();
      cond_taken = 1'b0;
      checks++;
      if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL drain_hold: addr=%h req=%b want 20 1", imem_addr, imem_req);
      end
      imem_ready = 1'b1;
      step();
      checks++;
      if (pc_out !== 32'h300 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0) begin
         errors++;
         $display("FAIL drain_exit: pc=%h v=%b i=%h want 300 0 0",
                  pc_out, ifid_valid, ifid_instr);
      end
      step();
      checks++;
      if (ifid_instr !== ~32'h300 || ifid_pc4 !== 32'h304 || ifid_valid !== 1'b1) begin
         errors++;
         $display("FAIL drain_target: i=%h p4=%h v=%b want %h 304 1",
                  ifid_instr, ifid_pc4, ifid_valid, ~32'h300);
      end
   endtask

   task automatic test_flush_hold_wrap();
      do_reset();
      step();
      step();
      hazard_stall = 1'b1;
      step();
      cond_taken = 1'b1;
      target_addr = 32'hFFFF_FFFE;
      step();
      cond_taken = 1'b0;
      hazard_stall = 1'b0;
      checks++;
      if (pc_out !== 32'hFFFF_FFFC || ifid_valid !== 1'b0 ||
          ifid_instr !== 32'd0 || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL hold_flush: pc=%h v=%b i=%h req=%b want FFFFFFFC 0 0 1",
                  pc_out, ifid_valid, ifid_instr, imem_req);
      end
      step();
      checks++;
      if (pc_out !== 32'd0 || ifid_pc4 !== 32'd0 || ifid_valid !== 1'b1 ||
          ifid_instr !== 32'h3) begin
         errors++;
         $display("FAIL pc_wrap: pc=%h p4=%h v=%b i=%h want 0 0 1 3",
                  pc_out, ifid_pc4, ifid_valid, ifid_instr);
      end
   endtask

   initial begin
      test_reset();
      test_wait_states();
      test_stall();
      test_branch();
      test_drain();
      test_flush_hold_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: owns the PC register and the IF/ID pipeline register.
- Drives a request/ready handshake to instruction memory, which may take several cycles per word.
- Applies hazard-unit stalls and condition-handler branch redirects (flushes) cycle-accurately.
- Sits between the instruction RAM, the condition handler and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID when a bubble is inserted.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk; 0 resets the block.
- hazard_stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- cond_taken  in  1  condition handler: branch taken; redirect to target_addr.
- target_addr  in  32  branch target; bits [1:0] ignored, treated as 0.
- imem_rdata  in  32  instruction word from memory; valid when imem_ready=1.
- imem_ready  in  1  memory has completed the current request.
- imem_req  out  1  fetch request to memory.
- imem_addr  out  32  fetch address; always equals pc_out.
- pc_out  out  32  current PC register.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (reset=0 at a clk edge):
  - Registers: pc=RESET_PC, state=BOOT, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, redirect_pending=0, hold_buf=0.
  - imem_req=0 while in BOOT.
  - Reset mid-request abandons the request. Memory must tolerate imem_req dropping without ready.
- States: BOOT, FETCH, HOLD, DRAIN. imem_req is a decode of state: 1 in FETCH and DRAIN, 0 in BOOT and HOLD.
- Request rule: while imem_req=1 and imem_ready=0, imem_addr must not change. Redirects are therefore deferred through DRAIN.
- BOOT: unconditionally goes to FETCH after one cycle. Inputs are ignored.
- FETCH (evaluated in priority order each edge):
  1. cond_taken & imem_ready: discard imem_rdata; pc<=target_addr&~3; IF/ID<=bubble; stay FETCH.
  2. cond_taken & !imem_ready: redirect_tgt<=target_addr&~3; IF/ID<=bubble; go to DRAIN.
  3. hazard_stall & imem_ready: hold_buf<=imem_rdata; pc and IF/ID unchanged; go to HOLD.
  4. hazard_stall & !imem_ready: everything held.
  5. imem_ready: ifid_instr<=imem_rdata, ifid_pc4<=pc+4, ifid_valid<=1; pc<=pc+4.
  6. otherwise (memory wait): IF/ID<=bubble; pc unchanged.
- HOLD:
  - cond_taken: drop hold_buf; pc<=target&~3; IF/ID<=bubble; go to FETCH. Flush beats stall.
  - hazard_stall: remain in HOLD; everything held.
  - else: IF/ID<={hold_buf, pc+4, 1}; pc<=pc+4; go to FETCH.
- DRAIN:
  - cond_taken again: redirect_tgt<=target&~3. The latest redirect wins.
  - imem_ready: discard data; pc<=redirect_tgt (or the same-cycle target if cond_taken); go to FETCH.
  - IF/ID holds a bubble throughout. hazard_stall is ignored.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 32'h0.
- Latency:
  - Zero-wait memory (ready in the same cycle as req) gives one instruction per cycle.
  - A taken branch costs exactly one bubble in IF/ID plus the memory latency of the new fetch.
- Bubble definition: ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc4 unchanged.

Test Plan:
- Reset, then release with ready tied 1 -> BOOT 1 cycle; PC sequence 0,4,8,C. ifid_instr follows memory words; ifid_pc4=4,8,C,10; ifid_valid=1 from the 3rd edge.
- Memory with 2 wait states (ready every 3rd cycle) -> imem_addr stable during waits; two bubbles between valid IF/ID entries; PC advances by 4 once per 3 cycles.
- hazard_stall for 3 cycles at PC=8 with ready=1 -> HOLD; pc_out=8 and IF/ID frozen for 3 cycles. On release, IF/ID gets word@8 with pc4=C; PC=C.
- cond_taken with target 32'h0000_0103 at PC=10, ready=1 -> next pc_out=0x100, one bubble, then word@0x100 with pc4=0x104.
- cond_taken (target 0x200) during a wait at PC=20, then a second cond_taken (target 0x300) before ready -> addr holds 0x20 until ready; data discarded; PC=0x300.
- cond_taken and hazard_stall together in HOLD; then PC=FFFF_FFFC with ready=1 -> flush wins, PC=target, bubble; then PC wraps to 0 with ifid_pc4=0.
